// File: rtl/capture_buffer_if.sv
// ---------------------------------------------------------------------------
// capture_buffer_if
// Bundles the sample stream, the stop request and the readout stream of the
// capture buffer. Widths follow the capture buffer's parameters.
//   slave  : the capture buffer side (consumes i_*, drives o_*)
//   master : the environment side (drives i_*, consumes o_*)
// Signals:
//   i_ce, i_data        sample enable and sample word
//   i_stopped           stop request from the holdoff/stop stage
//   o_waddr, o_primed   write pointer (oldest sample after stop), filled-once flag
//   i_rd_start          start readout of the frozen capture
//   o_rd_data/valid/last, i_rd_ready   readout stream with backpressure
//   o_done              readout finished (sticky until reset)
// ---------------------------------------------------------------------------
interface capture_buffer_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  i_ce;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_stopped;
  logic [ADDR_WIDTH-1:0] o_waddr;
  logic                  o_primed;
  logic                  i_rd_start;
  logic [DATA_WIDTH-1:0] o_rd_data;
  logic                  o_rd_valid;
  logic                  i_rd_ready;
  logic                  o_rd_last;
  logic                  o_done;

  modport slave (
    input  i_ce, i_data, i_stopped, i_rd_start, i_rd_ready,
    output o_waddr, o_primed, o_rd_data, o_rd_valid, o_rd_last, o_done
  );

  modport master (
    output i_ce, i_data, i_stopped, i_rd_start, i_rd_ready,
    input  o_waddr, o_primed, o_rd_data, o_rd_valid, o_rd_last, o_done
  );
endinterface

// File: rtl/capture_buffer.sv
// ---------------------------------------------------------------------------
// capture_buffer
// Circular capture memory of 2**ADDR_WIDTH sample words. Samples are written
// continuously until a stop request arrives after the memory has been filled
// once; the frozen capture can then be read out once, oldest word first,
// through a valid/ready stream.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; has priority over every other input
//   bus    capture_buffer_if.slave (sample input, stop, readout stream)
// Readout pipeline: synchronous RAM read register (stage 1) followed by a
// registered output stage. Stage 1 only reloads when its word moves on, so a
// stall simply freezes both stages and no word is lost or repeated.
// ---------------------------------------------------------------------------
module capture_buffer #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  capture_buffer_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = (ADDR_WIDTH+1)'(0);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_LAST  = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL  = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_FILL    = 3'd0,
    ST_PRIMED  = 3'd1,
    ST_STOPPED = 3'd2,
    ST_READOUT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t                state_q,     state_d;
  logic [ADDR_WIDTH-1:0] waddr_q,     waddr_d;
  logic                  primed_q,    primed_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q,    rd_ptr_d;
  logic [ADDR_WIDTH:0]   word_cnt_q,  word_cnt_d;   // words issued to the RAM
  logic                  s1_valid_q,  s1_valid_d;
  logic                  s1_last_q,   s1_last_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic                  out_last_q,  out_last_d;
  logic                  done_q,      done_d;
  logic [DATA_WIDTH-1:0] ram_q;

  logic wr_en_s;
  logic rd_en_s;
  logic load_out_s;
  logic accept_s;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Next-state, pointer and readout-pipeline control.
  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    primed_d    = primed_q;
    rd_ptr_d    = rd_ptr_q;
    word_cnt_d  = word_cnt_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = done_q;
    wr_en_s     = 1'b0;
    rd_en_s     = 1'b0;
    // Output stage takes stage 1 when it is empty or its word leaves now.
    load_out_s  = s1_valid_q && (!out_valid_q || bus.i_rd_ready);
    accept_s    = out_valid_q && bus.i_rd_ready;

    case (state_q)
      ST_FILL: begin
        // Stop requests are ignored until the memory is full once.
        if (bus.i_ce) begin
          wr_en_s = 1'b1;
          waddr_d = waddr_q + ADDR_ONE;
          if (waddr_q == ADDR_MAX) begin
            primed_d = 1'b1;
            state_d  = ST_PRIMED;
          end else begin
            state_d  = ST_FILL;
          end
        end else begin
          wr_en_s = 1'b0;
        end
      end

      ST_PRIMED: begin
        // The stop cycle's sample is dropped so o_waddr points at the oldest word.
        if (bus.i_stopped) begin
          state_d = ST_STOPPED;
        end else if (bus.i_ce) begin
          wr_en_s = 1'b1;
          waddr_d = waddr_q + ADDR_ONE;
        end else begin
          wr_en_s = 1'b0;
        end
      end

      ST_STOPPED: begin
        if (bus.i_rd_start) begin
          state_d    = ST_READOUT;
          rd_ptr_d   = waddr_q;
          word_cnt_d = CNT_ZERO;
          s1_valid_d = 1'b0;
          s1_last_d  = 1'b0;
        end else begin
          state_d    = ST_STOPPED;
        end
      end

      ST_READOUT: begin
        // Issue a RAM read whenever stage 1 will be free after this edge.
        rd_en_s = (word_cnt_q != CNT_FULL) && (!s1_valid_q || load_out_s);

        if (rd_en_s) begin
          rd_ptr_d   = rd_ptr_q + ADDR_ONE;
          word_cnt_d = word_cnt_q + CNT_ONE;
          s1_valid_d = 1'b1;
          s1_last_d  = (word_cnt_q == CNT_LAST);
        end else if (load_out_s) begin
          s1_valid_d = 1'b0;
        end else begin
          s1_valid_d = s1_valid_q;
        end

        if (load_out_s) begin
          out_valid_d = 1'b1;
          out_data_d  = ram_q;
          out_last_d  = s1_last_q;
        end else if (accept_s) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end

        if (accept_s && out_last_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_READOUT;
        end
      end

      ST_DONE: begin
        state_d = ST_DONE;
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FILL;
      waddr_q     <= '0;
      primed_q    <= 1'b0;
      rd_ptr_q    <= '0;
      word_cnt_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      primed_q    <= primed_d;
      rd_ptr_q    <= rd_ptr_d;
      word_cnt_q  <= word_cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  // Capture memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s && !reset) begin
      mem[waddr_q] <= bus.i_data;
    end
  end

  // Capture memory read port; the register holds its word while stalled.
  always_ff @(posedge clk) begin
    if (rd_en_s) begin
      ram_q <= mem[rd_ptr_q];
    end
  end

  assign bus.o_waddr    = waddr_q;
  assign bus.o_primed   = primed_q;
  assign bus.o_rd_data  = out_data_q;
  assign bus.o_rd_valid = out_valid_q;
  assign bus.o_rd_last  = out_last_q;
  assign bus.o_done     = done_q;

endmodule
